// File: rtl/imm_extend_if.sv
// Stream bundle between the decode-side producer and the execute-side consumer
// of the immediate extender.
interface imm_extend_if #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
);
   // A beat moves on a rising edge where valid & ready are both high. A producer
   // holds valid and its payload steady until that edge and never waits on ready.
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_imm;
   logic [1:0]           in_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_neg;

   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_neg
   );

   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_neg
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (sign / zero / upper / branch) with a 2-entry
// skid buffer between decode and execute.
module imm_extend_pipe #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   imm_extend_if.slave bus,
   output logic [1:0] dbg_state
);
   localparam int E = OUT_WIDTH - IN_WIDTH;

   // EMPTY: nothing held; HALF: output register only; FULL: output + skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state, state_next;

   logic                 in_ready_q;
   logic [OUT_WIDTH-1:0] or_data, sk_data;
   logic                 or_neg, sk_neg;
   logic                 accept, drain;
   logic                 or_load_in, or_load_sk, sk_load;

   logic [OUT_WIDTH-1:0] sext, zext, upper, branch, ext;
   logic                 neg;

   assign sext   = {{E{bus.in_imm[IN_WIDTH-1]}}, bus.in_imm};
   assign zext   = {{E{1'b0}}, bus.in_imm};
   assign upper  = {bus.in_imm, {E{1'b0}}};
   assign branch = {sext[OUT_WIDTH-3:0], 2'b00};
   assign neg    = bus.in_imm[IN_WIDTH-1];

   always_comb begin
      ext = sext;
      case (bus.in_mode)
         2'b00:   ext = sext;
         2'b01:   ext = zext;
         2'b10:   ext = upper;
         default: ext = branch;
      endcase
   end

   assign accept = bus.in_valid & in_ready_q;
   assign drain  = (state != ST_EMPTY) & bus.out_ready;

   always_comb begin
      state_next = state;
      or_load_in = 1'b0;
      or_load_sk = 1'b0;
      sk_load    = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               or_load_in = 1'b1;
               state_next = ST_HALF;
            end
         end
         ST_HALF: begin
            if (drain) begin
               if (accept) or_load_in = 1'b1;
               else        state_next = ST_EMPTY;
            end else if (accept) begin
               sk_load    = 1'b1;
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            // Skid entry always moves forward first so ordering stays FIFO.
            if (drain) begin
               or_load_sk = 1'b1;
               if (accept) sk_load    = 1'b1;
               else        state_next = ST_HALF;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != ST_FULL);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_data <= '0;
         or_neg  <= 1'b0;
         sk_data <= '0;
         sk_neg  <= 1'b0;
      end else begin
         if (or_load_sk) begin
            or_data <= sk_data;
            or_neg  <= sk_neg;
         end else if (or_load_in) begin
            or_data <= ext;
            or_neg  <= neg;
         end
         if (sk_load) begin
            sk_data <= ext;
            sk_neg  <= neg;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state != ST_EMPTY);
   assign bus.out_data  = or_data;
   assign bus.out_neg   = or_neg;
   assign dbg_state     = state;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: modes, backpressure, throughput, reset.
module tb_imm_extend_pipe;
   localparam int IW = 16;
   localparam int OW = 32;

   localparam logic [IW-1:0] T_IMM  [9] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h0004,
                                            16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234};
   localparam logic [1:0]    T_MODE [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
   localparam logic [OW-1:0] T_EXP  [9] = '{32'hFFFF8001, 32'h00008001, 32'h80010000,
                                            32'hFFFFFFFC, 32'h00000010, 32'h00007FFF,
                                            32'h0000FFFF, 32'hFFFE0000, 32'h12340000};
   localparam logic          T_NEG  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    dbg_state;
   int            checks = 0;
   int            errors = 0;
   logic [OW-1:0] exp_q[$];

   imm_extend_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

   imm_extend_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] ref_ext(input logic [IW-1:0] imm, input logic [1:0] mode);
      int s;
      s = int'($signed(imm));
      case (mode)
         2'd0:    return 32'(s);
         2'd1:    return {16'h0000, imm};
         2'd2:    return {imm, 16'h0000};
         default: return 32'(s * 4);
      endcase
   endfunction

   task automatic drive_beat(input logic [IW-1:0] imm, input logic [1:0] mode);
      bus.in_valid = 1'b1;
      bus.in_imm   = imm;
      bus.in_mode  = mode;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = 2'd0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", bus.out_data); end
      checks++; if (bus.out_neg !== 1'b0) begin errors++; $display("FAIL reset_out_neg got %b exp 0", bus.out_neg); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_modes();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive_beat(T_IMM[i], T_MODE[i]);
         @(negedge clk);
         idle();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mode_valid[%0d] got %b exp 1", i, bus.out_valid); end
         checks++; if (bus.out_data !== T_EXP[i]) begin errors++; $display("FAIL mode_data[%0d] got %h exp %h", i, bus.out_data, T_EXP[i]); end
         checks++; if (bus.out_neg !== T_NEG[i]) begin errors++; $display("FAIL mode_neg[%0d] got %b exp %b", i, bus.out_neg, T_NEG[i]); end
      end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mode_drained got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      int n_out, first_cyc, last_cyc;
      logic accept_now;
      logic [OW-1:0] e;
      bus.out_ready = 1'b0;
      drive_beat(16'h00AA, 2'd0);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_data !== 32'h000000AA) begin errors++; $display("FAIL bp_data_a got %h exp 000000aa", bus.out_data); end
      drive_beat(16'h8002, 2'd1);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.in_ready); end
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL bp_full_state got %0d exp 2", dbg_state); end
      drive_beat(16'h0003, 2'd2);
      repeat (3) begin
         @(negedge clk);
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready got %b exp 0", bus.in_ready); end
         checks++; if (bus.out_data !== 32'h000000AA || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold_data got %h/%b exp 000000aa/1", bus.out_data, bus.out_valid);
         end
      end
      exp_q.push_back(32'h000000AA);
      exp_q.push_back(32'h00008002);
      exp_q.push_back(32'h00030000);
      bus.out_ready = 1'b1;
      n_out = 0; first_cyc = -1; last_cyc = -1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (bus.out_valid) begin
            n_out++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL bp_extra_beat got %h exp none", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL bp_order got %h exp %h", bus.out_data, e); end
            end
         end
         accept_now = bus.in_valid && bus.in_ready;
         @(negedge clk);
         if (accept_now) idle();
      end
      checks++; if (n_out != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", n_out); end
      checks++; if (last_cyc - first_cyc != 2) begin errors++; $display("FAIL bp_gap got span %0d exp 2", last_cyc - first_cyc); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing got %0d left exp 0", exp_q.size()); end
      exp_q.delete();
      idle();
   endtask

   task automatic test_back_to_back();
      logic [IW-1:0] imm;
      logic [1:0]    mode;
      logic [OW-1:0] e;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         imm  = IW'($urandom_range(0, 65535));
         mode = 2'($urandom_range(0, 3));
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, bus.in_ready); end
         drive_beat(imm, mode);
         exp_q.push_back(ref_ext(imm, mode));
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
            errors++; $display("FAIL b2b_data[%0d] got %h/%b exp %h/1", k, bus.out_data, bus.out_valid, e);
         end
      end
      idle();
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      drive_beat(16'h1111, 2'd0);
      @(negedge clk);
      drive_beat(16'h2222, 2'd0);
      @(negedge clk);
      drive_beat(16'h3333, 2'd0);
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rm_full_state got %0d exp 2", dbg_state); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rm_out_data got %h exp 00000000", bus.out_data); end
      @(negedge clk);
      rst = 1'b0;
      idle();
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_accept got %b exp 0", bus.out_valid); end
      bus.out_ready = 1'b1;
      drive_beat(16'h8005, 2'd3);
      @(negedge clk);
      idle();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFE0014) begin
         errors++; $display("FAIL rm_first_beat got %h/%b exp fffe0014/1", bus.out_data, bus.out_valid);
      end
      checks++; if (bus.out_neg !== 1'b1) begin errors++; $display("FAIL rm_first_neg got %b exp 1", bus.out_neg); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_drained got %b exp 0", bus.out_valid); end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
